pe_job_sched: RTL and testbench
===============================

PE_JOB_SCHED -- requirements
Module: pe_job_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one 8x8 PE cluster (2..8).
REQ-002 Parameter ROWS, default 8: cluster rows/columns.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester job request, level; held until its resp handshake.
REQ-006 req_klen  input  NREQ*4  per-requester inner-dimension length; slice i belongs to req[i].
REQ-007 gnt_pulse  output  1  one-cycle pulse when a job is granted.
REQ-008 gnt_id  output  clog2(NREQ)  index of the current job owner; valid from gnt_pulse until resp handshake.
REQ-009 cl_rst_n  output  1  synchronous clear to the cluster, low for exactly one cycle per job.
REQ-010 feed_en  output  ROWS  row r operand-valid strobe to the cluster.
REQ-011 feed_k  output  ROWS*4  per-row operand index; parent muxes operands with gnt_id/feed_k.
REQ-012 row_done  output  ROWS  per-row input-done flags to the cluster.
REQ-013 cl_done_all  input  1  AND of all 64 PE done flags.
REQ-014 resp_valid  output  1  job result available in the cluster.
REQ-015 resp_ready  input  1  owner has captured the results.
REQ-016 resp_err  output  1  job ended by watchdog; valid with resp_valid.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, CLR, FEED, DRAIN and RESP.
REQ-019 IDLE with any req bit set SHALL go to CLR. In that same cycle it SHALL:
- pulse gnt_pulse;
- latch gnt_id from a round-robin choice;
- latch L = req_klen[gnt_id], with 0 clamped to 1.
REQ-020 Round-robin: the search SHALL start at (last gnt_id + 1) mod NREQ; the pointer SHALL start at 0 after reset.
REQ-021 CLR SHALL last one cycle with cl_rst_n=0, then go to FEED with counter cnt=0.
REQ-022 FEED row r timing, with cnt incrementing every cycle:
- feed_en[r]=1 and feed_k[r]=cnt-r when r<=cnt<r+L;
- otherwise feed_en[r]=0 and feed_k[r]=0.
REQ-023 row_done[r] SHALL set when cnt reaches r+L and SHALL hold until the next CLR.
REQ-024 FEED SHALL last exactly L+ROWS-1 cycles, then go to DRAIN.
REQ-025 DRAIN SHALL go to RESP on the first cycle cl_done_all=1.
REQ-026 RESP SHALL hold resp_valid=1 until resp_ready=1; that handshake cycle SHALL return to IDLE.
REQ-027 After a handshake, arbitration SHALL occur no earlier than the following IDLE cycle (no same-cycle re-grant).
REQ-028 A req drop by the owner mid-job SHALL be ignored; the job completes and resp_valid still asserts.
REQ-029 req and req_klen of non-owners SHALL be ignored while busy.
REQ-030 resp_ready outside RESP SHALL be ignored.

Reset
REQ-031 rst_n low SHALL force, asynchronously and including mid-job:
- state=IDLE and RR pointer=0;
- gnt_pulse=0, gnt_id=0, cl_rst_n=0, feed_en=0, feed_k=0, row_done=0;
- resp_valid=0, resp_err=0, busy=0.
REQ-032 cl_rst_n SHALL be 1 in every state except CLR once rst_n is high.

Configuration
REQ-033 Macro PE_SCHED_WATCHDOG_EN, when defined, SHALL add an 8-bit DRAIN timer:
- if cl_done_all stays 0 for 255 consecutive DRAIN cycles, the FSM SHALL enter RESP with resp_err=1;
- the timer SHALL clear on DRAIN entry.
REQ-034 Without PE_SCHED_WATCHDOG_EN:
- resp_err SHALL be constant 0;
- DRAIN SHALL wait indefinitely;
- no timer logic SHALL be present.

Structure
REQ-035 Package pe_sched_pkg SHALL hold:
- the state enum;
- ROWS, KW=4 and WD_LIMIT=255;
- the clog2 helper.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, pointer -> one-hot grant and index).

Verification
REQ-037 Single job: req=0001, klen0=4, cl_done_all rises 3 cycles after FEED ends, resp_ready held 1.
- gnt_id=0;
- cl_rst_n low one cycle;
- FEED lasts 11 cycles, and row 7 feeds k=0..3 at cnt=7..10;
- resp_valid asserts after DRAIN, and busy falls after the handshake.
REQ-038 Contention: req=1111 held for four jobs -> grants in order 0,1,2,3, then 0 again.
REQ-039 klen=0 -> treated as L=1; FEED lasts 8 cycles; each row has exactly one feed_en pulse with k=0.
REQ-040 Reset mid-FEED (cnt=5) -> all outputs reach reset values immediately; after release, the next grant is id 0.
REQ-041 Watchdog on, cl_done_all held 0 -> resp_valid=1 and resp_err=1 after 255 DRAIN cycles; watchdog off -> FSM stays in DRAIN.
REQ-042 resp_ready low for 5 RESP cycles -> resp_valid stays 1 and gnt_id is stable; a handshake with req=0010 pending -> gnt_pulse no earlier than 2 cycles later.

Source files
------------

// File: rtl/pe_sched_pkg.sv
// Shared types and constants for the PE job scheduler: FSM state encoding,
// cluster geometry, operand index width, DRAIN watchdog limit and a clog2 helper.
package pe_sched_pkg;

    localparam int ROWS     = 8;
    localparam int KW       = 4;
    localparam int WD_LIMIT = 255;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_job_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after i_ptr
// (wrapping), returning both a one-hot grant and its index.
module rr_arbiter
    import pe_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_j;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_j     = '0;
        for (int i = 0; i < N; i++) begin
            // candidate index = (ptr + i) mod N without a divider
            w_sum = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
            w_j = w_sum[IW-1:0];
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/pe_job_sched.sv
// Shares one PE cluster among NREQ requesters: grant, clear, skewed operand feed,
// drain and response. Define PE_SCHED_WATCHDOG_EN to add the DRAIN watchdog.
module pe_job_sched
    import pe_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ROWS = pe_sched_pkg::ROWS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*KW-1:0]         req_klen,
    output logic                       gnt_pulse,
    output logic [clog2(NREQ)-1:0]     gnt_id,
    output logic                       cl_rst_n,
    output logic [ROWS-1:0]            feed_en,
    output logic [ROWS*KW-1:0]         feed_k,
    output logic [ROWS-1:0]            row_done,
    input  logic                       cl_done_all,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_err,
    output logic                       busy,
    output state_e                     dbg_state
);

    localparam int IW = clog2(NREQ);
    localparam int CW = KW + clog2(ROWS) + 1;

    state_e        r_state;
    state_e        w_next;
    logic          w_grant;
    logic [CW-1:0] r_cnt;
    logic [KW-1:0] r_len;
    logic [IW-1:0] r_gnt_id;
    logic [IW-1:0] r_ptr;
    logic          r_gnt_pulse;
    logic          r_done_vld;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0] w_idx;
    logic [KW-1:0] w_klen;
    logic [CW-1:0] w_feed_end;

    rr_arbiter #(.N(NREQ)) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_klen     = req_klen[int'(w_idx)*KW +: KW];
    // last FEED cycle has cnt = L + ROWS - 2
    assign w_feed_end = CW'(r_len) + CW'(ROWS - 2);

`ifdef PE_SCHED_WATCHDOG_EN
    logic [7:0] r_wd;
    logic       r_err;
    logic       w_wd_fire;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
`ifdef PE_SCHED_WATCHDOG_EN
        w_wd_fire = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (|w_gnt) begin
                    w_next  = S_CLR;
                    w_grant = 1'b1;
                end
            end
            S_CLR:  w_next = S_FEED;
            S_FEED: begin
                if (r_cnt == w_feed_end) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (cl_done_all) begin
                    w_next = S_RESP;
                end
`ifdef PE_SCHED_WATCHDOG_EN
                else if (r_wd == 8'(WD_LIMIT - 1)) begin
                    w_next    = S_RESP;
                    w_wd_fire = 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_len       <= '0;
            r_gnt_id    <= '0;
            r_ptr       <= '0;
            r_gnt_pulse <= 1'b0;
            r_done_vld  <= 1'b0;
        end else begin
            r_gnt_pulse <= w_grant;
            if (w_grant) begin
                r_gnt_id   <= w_idx;
                r_ptr      <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
                r_len      <= (w_klen == '0) ? KW'(1) : w_klen;
                r_done_vld <= 1'b0;
            end
            // cnt keeps counting into the FEED exit so the last row sees r+L
            if (r_state == S_CLR) begin
                r_cnt      <= '0;
                r_done_vld <= 1'b1;
            end else if (r_state == S_FEED) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

`ifdef PE_SCHED_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_FEED)       r_wd <= '0;
            else if (r_state == S_DRAIN) r_wd <= r_wd + 8'd1;
            if (w_grant)        r_err <= 1'b0;
            else if (w_wd_fire) r_err <= 1'b1;
        end
    end
    assign resp_err = r_err;
`else
    assign resp_err = 1'b0;
`endif

    always_comb begin
        feed_en  = '0;
        feed_k   = '0;
        row_done = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_state == S_FEED && r_cnt >= CW'(r) && r_cnt < CW'(r) + CW'(r_len)) begin
                feed_en[r]         = 1'b1;
                feed_k[r*KW +: KW] = KW'(r_cnt - CW'(r));
            end
            if (r_done_vld && r_cnt >= CW'(r) + CW'(r_len)) row_done[r] = 1'b1;
        end
    end

    assign gnt_pulse  = r_gnt_pulse;
    assign gnt_id     = r_gnt_id;
    assign cl_rst_n   = rst_n && (r_state != S_CLR);
    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_pe_job_sched.sv
// Bench for pe_job_sched: directed jobs, grant/response scoreboard and
// cycle-accurate feed checks; follows PE_SCHED_WATCHDOG_EN when defined.
module tb_pe_job_sched;
    import pe_sched_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_klen;
    logic        gnt_pulse;
    logic [1:0]  gnt_id;
    logic        cl_rst_n;
    logic [7:0]  feed_en;
    logic [31:0] feed_k;
    logic [7:0]  row_done;
    logic        cl_done_all;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_err;
    logic        busy;
    state_e      dbg_state;

    pe_job_sched #(.NREQ(4), .ROWS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_klen    (req_klen),
        .gnt_pulse   (gnt_pulse),
        .gnt_id      (gnt_id),
        .cl_rst_n    (cl_rst_n),
        .feed_en     (feed_en),
        .feed_k      (feed_k),
        .row_done    (row_done),
        .cl_done_all (cl_done_all),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_err    (resp_err),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_gnt_q[$];
    logic [0:0] exp_err_q[$];
    logic [1:0] e_gnt;
    logic [0:0] e_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: grants and response handshakes
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt_pulse) begin
                if (exp_gnt_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL gnt_unexpected: got gnt_id %0d, expected no grant", gnt_id);
                end else begin
                    e_gnt = exp_gnt_q.pop_front();
                    chk("gnt_id", 64'(gnt_id), 64'(e_gnt));
                end
            end
            if (resp_valid && resp_ready) begin
                if (exp_err_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL resp_unexpected: got resp handshake, expected none");
                end else begin
                    e_err = exp_err_q.pop_front();
                    chk("resp_err", 64'(resp_err), 64'(e_err));
                end
            end
        end
    end

    // starts in the CLR cycle, returns in the first DRAIN cycle
    task automatic feed_phase(input int L);
        logic [7:0]  e_en;
        logic [7:0]  e_done;
        logic [31:0] e_k;
        int          n;
        int          pulses[8];
        chk("clr_cl_rst_n", 64'(cl_rst_n), 64'(0));
        chk("clr_gnt_pulse", 64'(gnt_pulse), 64'(1));
        chk("clr_row_done", 64'(row_done), 64'(0));
        chk("clr_busy", 64'(busy), 64'(1));
        cyc();
        chk("feed_cl_rst_n", 64'(cl_rst_n), 64'(1));
        chk("feed_gnt_pulse", 64'(gnt_pulse), 64'(0));
        foreach (pulses[r]) pulses[r] = 0;
        n = 0;
        while (dbg_state == S_FEED && n < 40) begin
            e_en = '0; e_k = '0; e_done = '0;
            for (int r = 0; r < 8; r++) begin
                if (n >= r && n < r + L) begin
                    e_en[r] = 1'b1;
                    e_k[r*4 +: 4] = 4'(n - r);
                end
                if (n >= r + L) e_done[r] = 1'b1;
                if (feed_en[r]) pulses[r]++;
            end
            chk("feed_en", 64'(feed_en), 64'(e_en));
            chk("feed_k", 64'(feed_k), 64'(e_k));
            chk("feed_row_done", 64'(row_done), 64'(e_done));
            n++;
            cyc();
        end
        chk("feed_len", 64'(n), 64'(L + 7));
        chk("drain_row_done", 64'(row_done), 64'(8'hFF));
        for (int r = 0; r < 8; r++) chk("row_pulses", 64'(pulses[r]), 64'(L));
    endtask

    // called in an IDLE cycle; returns in the IDLE cycle after the handshake
    task automatic run_job(input logic [3:0] rq, input logic [15:0] kl, input logic [3:0] rq_after,
                           input int exp_id, input int L, input int ready_delay, input bit drop_mid);
        exp_gnt_q.push_back(2'(exp_id));
        exp_err_q.push_back(1'b0);
        req        = rq;
        req_klen   = kl;
        resp_ready = (ready_delay == 0);
        cyc();
        if (drop_mid) req = rq & ~(4'b0001 << exp_id);
        feed_phase(L);
        cyc();
        cyc();
        chk("drain_no_resp", 64'(resp_valid), 64'(0));
        cl_done_all = 1'b1;
        cyc();
        cl_done_all = 1'b0;
        chk("resp_valid", 64'(resp_valid), 64'(1));
        for (int i = 0; i < ready_delay; i++) begin
            chk("resp_hold", 64'(resp_valid), 64'(1));
            chk("gnt_id_stable", 64'(gnt_id), 64'(exp_id));
            cyc();
        end
        resp_ready = 1'b1;
        req        = rq_after;
        chk("resp_at_handshake", 64'(resp_valid), 64'(1));
        cyc();
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_no_regrant", 64'(gnt_pulse), 64'(0));
        chk("idle_row_done_hold", 64'(row_done), 64'(8'hFF));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk(nm, {gnt_pulse, gnt_id, cl_rst_n, feed_en, feed_k, row_done, resp_valid, resp_err, busy}, 64'(0));
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        req         = 4'hF;
        req_klen    = 16'h0;
        cl_done_all = 1'b0;
        resp_ready  = 1'b0;
        #23;
        chk_reset_outputs("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'h0;
        #1;
        chk("post_reset_cl_rst_n", 64'(cl_rst_n), 64'(1));
        chk("post_reset_busy", 64'(busy), 64'(0));
        cyc();

        // contention: klen0=5 klen1=3 klen2=1 klen3=2, all held
        run_job(4'hF, 16'h2135, 4'hF, 0, 5, 0, 0);
        run_job(4'hF, 16'h2135, 4'hF, 1, 3, 0, 0);
        run_job(4'hF, 16'h2135, 4'hF, 2, 1, 0, 0);
        run_job(4'hF, 16'h2135, 4'hF, 3, 2, 0, 0);
        run_job(4'hF, 16'h2135, 4'h0, 0, 5, 0, 0);

        // single job, klen0=4, resp_ready held high
        run_job(4'b0001, 16'h0004, 4'h0, 0, 4, 0, 0);

        // klen=0 clamps to 1; owner drops req mid-job
        run_job(4'b0100, 16'h0000, 4'h0, 2, 1, 0, 1);

        // slow handshake with requester 1 pending, then its grant
        run_job(4'b0011, 16'h0034, 4'b0010, 0, 4, 5, 0);
        run_job(4'b0010, 16'h0034, 4'h0, 1, 3, 0, 0);

        // reset mid-FEED at cnt=5
        exp_gnt_q.push_back(2'd3);
        req      = 4'b1000;
        req_klen = 16'h6000;
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) cyc();
        chk("pre_reset_state_feed", 64'(dbg_state), 64'(S_FEED));
        chk("pre_reset_feed_en", 64'(feed_en), 64'(8'h3F));
        rst_n = 1'b0;
        req   = 4'hF;
        #1;
        chk_reset_outputs("mid_feed_reset_outputs");
        cyc();
        cyc();
        rst_n = 1'b1;
        run_job(4'hF, 16'h0002, 4'h0, 0, 2, 0, 0);

        // cluster never reports done
        exp_gnt_q.push_back(2'd0);
        req        = 4'b0001;
        req_klen   = 16'h0001;
        resp_ready = 1'b1;
        cyc();
        feed_phase(1);
`ifdef PE_SCHED_WATCHDOG_EN
        exp_err_q.push_back(1'b1);
        n = 0;
        while (dbg_state == S_DRAIN && n < 400) begin
            n++;
            cyc();
        end
        chk("wd_drain_cycles", 64'(n), 64'(255));
        chk("wd_resp_valid", 64'(resp_valid), 64'(1));
        chk("wd_resp_err", 64'(resp_err), 64'(1));
`else
        exp_err_q.push_back(1'b0);
        n = 0;
        for (int i = 0; i < 300; i++) cyc();
        chk("nowd_still_drain", 64'(dbg_state), 64'(S_DRAIN));
        chk("nowd_no_resp", 64'(resp_valid), 64'(0));
        cl_done_all = 1'b1;
        cyc();
        cl_done_all = 1'b0;
        chk("nowd_resp_valid", 64'(resp_valid), 64'(1));
`endif
        req = 4'h0;
        cyc();
        chk("final_busy", 64'(busy), 64'(0));
        cyc();
        chk("gnt_queue_empty", 64'(exp_gnt_q.size()), 64'(0));
        chk("err_queue_empty", 64'(exp_err_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
